serial_sub: RTL and testbench

Bit-serial N-bit subtractor built around the single-bit full subtractor cell. It computes a − b − bin as follows:
- Latches two operands on a start request.
- Feeds them LSB-first through one full-subtract slice, one bit per clock.
- Carries the borrow in a flip-flop between bits.
- Presents the assembled difference and final borrow with a one-cycle done pulse.

It is the sequential stage that drives the full subtractor cell for multi-bit operands, trading area for WIDTH cycles of latency.

---
 rtl/serial_sub.sv | 89 ++++++++
 tb/tb_serial_sub.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial WIDTH-bit subtractor (a - b - bin), one full-subtract slice per clock
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             borrow;
    logic [CW-1:0]    count;

    logic             d;
    logic             borrow_next;
    logic [WIDTH-1:0] res_next;

    // Single full-subtractor slice fed from the LSBs of the operand shifters.
    assign d           = a_sh[0] ^ b_sh[0] ^ borrow;
    assign borrow_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow);
    assign res_next    = {d, res_sh[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            borrow <= 1'b0;
            count  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        borrow <= bin;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next;
                    borrow <= borrow_next;
                    count  <= count + 1'b1;
                    // The last slice result goes straight to the output register.
                    if (count == LAST) begin
                        diff  <= res_next;
                        bout  <= borrow_next;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// tb/tb_serial_sub.sv - scoreboard bench for serial_sub at WIDTH=8 and WIDTH=4
module tb_serial_sub;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, bin8, busy8, done8, bout8;
    logic [7:0] a8, b8, diff8;
    logic       start4, bin4, busy4, done4, bout4;
    logic [3:0] a4, b4, diff4;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int diff;
        int bout;
        int cyc;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_sub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );

    serial_sub #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done8) begin
            if (q8.size() == 0) begin
                chk("w8_unexpected_done", 1, 0);
            end else begin
                e = q8.pop_front();
                chk("w8_diff", int'(diff8), e.diff);
                chk("w8_bout", int'(bout8), e.bout);
                chk("w8_latency", cyc, e.cyc);
            end
        end
        if (rst_n && done4) begin
            if (q4.size() == 0) begin
                chk("w4_unexpected_done", 1, 0);
            end else begin
                e = q4.pop_front();
                chk("w4_diff", int'(diff4), e.diff);
                chk("w4_bout", int'(bout4), e.bout);
                chk("w4_latency", cyc, e.cyc);
            end
        end
    end

    task automatic wait_idle8();
        int n = 0;
        while (busy8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy8) chk("w8_idle_timeout", 1, 0);
    endtask

    task automatic wait_idle4();
        int n = 0;
        while (busy4 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy4) chk("w4_idle_timeout", 1, 0);
    endtask

    // Issue one 8-bit operation; returns just after the accepting edge with start low.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                       input int ed, input int eb);
        exp_t e;
        wait_idle8();
        @(negedge clk);
        a8 = a; b8 = b; bin8 = bi; start8 = 1'b1;
        @(posedge clk);
        #1;
        e.diff = ed; e.bout = eb; e.cyc = cyc + 8;
        q8.push_back(e);
        start8 = 1'b0;
    endtask

    task automatic op4(input int a, input int b, input int bi);
        exp_t e;
        wait_idle4();
        @(negedge clk);
        a4 = 4'(a); b4 = 4'(b); bin4 = bi[0]; start4 = 1'b1;
        @(posedge clk);
        #1;
        e.diff = (a - b - bi) & 15;
        e.bout = (a < b + bi) ? 1 : 0;
        e.cyc  = cyc + 4;
        q4.push_back(e);
        start4 = 1'b0;
    endtask

    initial begin
        exp_t e;
        int   n;
        rst_n = 1'b0;
        start8 = 0; a8 = 0; b8 = 0; bin8 = 0;
        start4 = 0; a4 = 0; b4 = 0; bin4 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", int'(busy8), 0);
        chk("reset_done", int'(done8), 0);
        chk("reset_diff", int'(diff8), 0);
        chk("reset_bout", int'(bout8), 0);
        rst_n = 1'b1;

        // Basic operation and busy duration
        op8(8'h5A, 8'h3C, 1'b0, 'h1E, 0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy8) n++;
            else break;
        end
        chk("busy_cycles", n, 9);

        // Underflow and borrow-in corners
        op8(8'h00, 8'h01, 1'b0, 'hFF, 1);
        op8(8'h10, 8'h10, 1'b1, 'hFF, 1);
        op8(8'hFF, 8'h00, 1'b1, 'hFE, 0);

        // Start while busy is ignored
        op8(8'h33, 8'h11, 1'b0, 'h22, 0);
        repeat (3) @(negedge clk);
        a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_idle8();
        chk("ignored_start_idle", int'(busy8), 0);

        // Back-to-back with start held high
        wait_idle8();
        @(negedge clk);
        a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) repeat (10) @(posedge clk);
            #1;
            e.diff = 'h7F; e.bout = 0; e.cyc = cyc + 8;
            q8.push_back(e);
        end
        start8 = 1'b0;
        wait_idle8();
        @(negedge clk);

        // Asynchronous reset in the middle of SHIFT
        op8(8'hC3, 8'h5A, 1'b0, 'h69, 0);
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midreset_busy", int'(busy8), 0);
        chk("midreset_diff", int'(diff8), 0);
        chk("midreset_bout", int'(bout8), 0);
        chk("midreset_done", int'(done8), 0);
        if (q8.size() > 0) e = q8.pop_back();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        op8(8'hC3, 8'h5A, 1'b0, 'h69, 0);
        wait_idle8();

        // WIDTH=4 exhaustive
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int bi = 0; bi < 2; bi++)
                    op4(a, b, bi);
        wait_idle4();

        n = 0;
        while ((q8.size() != 0 || q4.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("queue8_drained", q8.size(), 0);
        chk("queue4_drained", q4.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
